divide_stream: RTL and testbench
================================

DIVIDE_STREAM -- requirements
Module: divide_stream

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- Q_BITS, 10, fractional bits of the signed fixed-point format.
- D_WIDTH, 32, operand and result width.
- FIFO_DEPTH, 16, output FIFO entries; power of two, at least 2.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clock, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-low.
- dividend, in, D_WIDTH, signed; valid while in_empty=0.
- divisor, in, D_WIDTH, signed; valid while in_empty=0.
- in_empty, in, 1, upstream first-word-fall-through FIFO empty.
- in_rd_en, out, 1, pop upstream; pulses one cycle per accepted operand pair.
- out_rd_en, in, 1, pop the output FIFO.
- out_dout, out, D_WIDTH, signed quotient at the output FIFO head.
- out_dz, out, 1, divide-by-zero flag travelling with out_dout.
- out_empty, out, 1, output FIFO empty.
- busy, out, 1, FSM not in IDLE.

Function
REQ-003 The FSM SHALL have four states: IDLE, LOAD, DIVIDE, WRITE.
REQ-004 IDLE SHALL assert in_rd_en for exactly one cycle and go to LOAD when in_empty=0; otherwise it SHALL stay in IDLE.
REQ-005 LOAD SHALL do all of the following:
- capture the sign as sign(dividend) XOR sign(divisor);
- take the operand magnitudes;
- left-shift the dividend magnitude by Q_BITS into a D_WIDTH+Q_BITS+1-bit working register;
- go to DIVIDE, or go straight to WRITE when divisor=0.
REQ-006 DIVIDE SHALL run restoring radix-2 division at one quotient bit per cycle for exactly D_WIDTH+Q_BITS cycles, then go to WRITE.
REQ-007 WRITE SHALL stay while the output FIFO is full, then write {dz, result} in one cycle and return to IDLE.
REQ-008 Latency from the in_rd_en pulse to the FIFO write SHALL be D_WIDTH+Q_BITS+2 cycles when not blocked (44 at the defaults); for divisor=0 it SHALL be 2 cycles.
REQ-009 Results SHALL be truncated toward zero, then negated when the sign is 1.
REQ-010 For divisor=0 the result SHALL be 2^(D_WIDTH-1)-1 when dividend>=0 and -2^(D_WIDTH-1) otherwise, with dz=1; all other results SHALL have dz=0.
REQ-011 Overflow handling SHALL follow Configuration; dz SHALL not be set for overflow.
REQ-012 The output FIFO SHALL be first-word-fall-through: out_dout/out_dz are valid whenever out_empty=0.
REQ-013 out_rd_en while out_empty=1 SHALL be ignored.
REQ-014 The full flag SHALL be evaluated before a same-cycle pop, so a WRITE against a full FIFO waits one extra cycle even if out_rd_en=1.
REQ-015 A simultaneous write and read on a non-empty, non-full FIFO SHALL keep the occupancy unchanged.
REQ-016 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 in_rd_en SHALL never be asserted outside IDLE.
REQ-018 Only one operation SHALL be in flight at a time.

Reset
REQ-019 While reset=0 at a clock edge, all of the following SHALL hold:
- FSM goes to IDLE;
- FIFO pointers clear;
- in_rd_en=0, busy=0, out_empty=1, out_dout=0, out_dz=0.
REQ-020 A reset mid-DIVIDE or mid-WRITE SHALL discard the operation; no partial result is written.
REQ-021 The first in_rd_en after reset SHALL occur no earlier than the first cycle after reset returns to 1.

Configuration
REQ-022 With DIVIDE_SAT_EN defined, a quotient magnitude outside D_WIDTH signed range SHALL clamp to 2^(D_WIDTH-1)-1 or -2^(D_WIDTH-1) according to sign.
REQ-023 Without DIVIDE_SAT_EN, the result SHALL be the low D_WIDTH bits of the two's-complement full-width quotient, and no saturation logic shall be built.

Verification (Q_BITS=10, D_WIDTH=32, FIFO_DEPTH=16)
REQ-024 Basic divide: dividend=3072 (3.0), divisor=2048 (2.0):
- out_dout=1536 (1.5), out_dz=0;
- write 44 cycles after in_rd_en.
REQ-025 Signed divide: dividend=-7680, divisor=2560 -> out_dout=-3072, out_dz=0.
REQ-026 Divide by zero:
- 1024/0 -> 0x7FFFFFFF, out_dz=1, written 2 cycles after in_rd_en;
- -1024/0 -> 0x80000000, out_dz=1.
REQ-027 Overflow: dividend=0x40000000, divisor=1:
- with DIVIDE_SAT_EN -> 0x7FFFFFFF;
- without -> 0x00000000;
- out_dz=0 in both builds.
REQ-028 Backpressure: 17 operand pairs, out_rd_en=0 throughout:
- 16 results stored;
- 17th holds in WRITE with busy=1 and no further in_rd_en;
- one pop -> 17th written next cycle; order preserved.
REQ-029 Reset mid-operation: reset=0 for 1 cycle at DIVIDE cycle 20 -> out_empty stays 1, busy=0, and the next operand pair produces the correct result.

Source files
------------

// File: rtl/divide_stream.sv
// rtl/divide_stream.sv - signed fixed-point restoring divider feeding a first-word-fall-through result FIFO
// Define DIVIDE_SAT_EN to clamp out-of-range quotients; by default the low D_WIDTH bits are kept.

module divide_stream #(
  parameter int Q_BITS     = 10,
  parameter int D_WIDTH    = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic signed [D_WIDTH-1:0] dividend,
  input  logic signed [D_WIDTH-1:0] divisor,
  input  logic                      in_empty,
  output logic                      in_rd_en,
  input  logic                      out_rd_en,
  output logic signed [D_WIDTH-1:0] out_dout,
  output logic                      out_dz,
  output logic                      out_empty,
  output logic                      busy
);

  localparam int W    = D_WIDTH + Q_BITS;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(W);
  localparam logic [D_WIDTH-1:0] MAX_VAL = {1'b0, {(D_WIDTH-1){1'b1}}};
  localparam logic [D_WIDTH-1:0] MIN_VAL = {1'b1, {(D_WIDTH-1){1'b0}}};
`ifdef DIVIDE_SAT_EN
  localparam logic [W:0] POS_LIM = {{(W-D_WIDTH+2){1'b0}}, {(D_WIDTH-1){1'b1}}};
  localparam logic [W:0] NEG_LIM = POS_LIM + 1'b1;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, DIVIDE, WRITE} state_t;

  state_t               state_q, state_d;
  logic [D_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [D_WIDTH-1:0]   dm_q, dm_d;
  logic [D_WIDTH-1:0]   rem_q, rem_d;
  logic [W:0]           work_q, work_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sign_q, sign_d;
  logic                 dz_q, dz_d;

  logic [D_WIDTH-1:0]   mag_a, mag_b, q_lo, result;
  logic [D_WIDTH:0]     shifted;
  logic                 fifo_wr, fifo_rd, full;

  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]      count_q;
  logic [D_WIDTH:0]     mem_q [FIFO_DEPTH];
  logic [D_WIDTH:0]     head;

  assign mag_a   = a_q[D_WIDTH-1] ? -a_q : a_q;
  assign mag_b   = b_q[D_WIDTH-1] ? -b_q : b_q;
  assign q_lo    = work_q[D_WIDTH-1:0];
  assign shifted = {rem_q, work_q[W-1]};
  assign busy    = (state_q != IDLE);

  // Quotient magnitude occupies work_q[W-1:0] once all bits are shifted in; bit W stays zero.
  always_comb begin
    result = sign_q ? -q_lo : q_lo;
`ifdef DIVIDE_SAT_EN
    if (!sign_q && (work_q > POS_LIM)) begin
      result = MAX_VAL;
    end else if (sign_q && (work_q > NEG_LIM)) begin
      result = MIN_VAL;
    end
`endif
    if (dz_q) begin
      result = a_q[D_WIDTH-1] ? MIN_VAL : MAX_VAL;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    dm_d     = dm_q;
    rem_d    = rem_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    dz_d     = dz_q;
    in_rd_en = 1'b0;
    fifo_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        // Operands are captured on the pop edge because the upstream head advances after it.
        if (!in_empty && reset) begin
          in_rd_en = 1'b1;
          a_d      = dividend;
          b_d      = divisor;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        sign_d  = a_q[D_WIDTH-1] ^ b_q[D_WIDTH-1];
        dm_d    = mag_b;
        work_d  = {{(Q_BITS+1){1'b0}}, mag_a} << Q_BITS;
        rem_d   = '0;
        cnt_d   = '0;
        dz_d    = (b_q == '0);
        state_d = (b_q == '0) ? WRITE : DIVIDE;
      end
      DIVIDE: begin
        if (shifted >= {1'b0, dm_q}) begin
          rem_d  = D_WIDTH'(shifted - {1'b0, dm_q});
          work_d = {work_q[W], work_q[W-2:0], 1'b1};
        end else begin
          rem_d  = shifted[D_WIDTH-1:0];
          work_d = {work_q[W], work_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (!full && reset) begin
          fifo_wr = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dm_q    <= '0;
      rem_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dm_q    <= dm_d;
      rem_q   <= rem_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      dz_q    <= dz_d;
    end
  end

  // Full is taken from the registered count, so a same-cycle pop does not free a slot.
  assign full      = (count_q == CNTW'(FIFO_DEPTH));
  assign out_empty = (count_q == '0);
  assign fifo_rd   = out_rd_en && !out_empty;
  assign head      = mem_q[rd_ptr_q];
  assign out_dout  = out_empty ? '0 : head[D_WIDTH-1:0];
  assign out_dz    = !out_empty && head[D_WIDTH];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CNTW'(fifo_wr) - CNTW'(fifo_rd);
    end
  end

  always_ff @(posedge clock) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= {dz_q, result};
    end
  end

endmodule

// File: tb/tb_divide_stream.sv
// tb/tb_divide_stream.sv - randomized self-checking bench for divide_stream against an arithmetic model
// Honours DIVIDE_SAT_EN for overflow expectations.

module tb_divide_stream;

  localparam int Q      = 10;
  localparam int D      = 32;
  localparam int DEPTH  = 16;
  // Cycles from the in_rd_en cycle until out_empty is first observed low.
  localparam int LAT    = D + Q + 3;
  localparam int LAT_DZ = 3;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic signed [D-1:0] dividend = '0;
  logic signed [D-1:0] divisor = '0;
  logic                in_empty = 1'b1;
  logic                in_rd_en;
  logic                out_rd_en = 1'b0;
  logic signed [D-1:0] out_dout;
  logic                out_dz;
  logic                out_empty;
  logic                busy;

  int          n_cmp = 0;
  int          n_err = 0;
  int          rd_count = 0;
  bit          pop_pending = 1'b0;
  logic [63:0] up_q[$];
  logic [32:0] exp_q[$];

  always #5 clock = ~clock;

  divide_stream #(.Q_BITS(Q), .D_WIDTH(D), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .dividend(dividend), .divisor(divisor),
    .in_empty(in_empty), .in_rd_en(in_rd_en), .out_rd_en(out_rd_en),
    .out_dout(out_dout), .out_dz(out_dz), .out_empty(out_empty), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input int a, input int b);
    longint ma, mb, q, s;
    logic [63:0] sv;
    if (b == 0) return {1'b1, (a >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000};
    ma = (a < 0) ? -longint'(a) : longint'(a);
    mb = (b < 0) ? -longint'(b) : longint'(b);
    q  = (ma <<< Q) / mb;
    s  = ((a < 0) != (b < 0)) ? -q : q;
`ifdef DIVIDE_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    sv = s;
    return {1'b0, sv[31:0]};
  endfunction

  // Upstream FWFT FIFO: pop takes effect after the edge that saw in_rd_en.
  always @(negedge clock) begin
    logic [63:0] tmp;
    if (pop_pending && up_q.size() > 0) begin
      tmp = up_q.pop_front();
      rd_count++;
    end
    if (up_q.size() > 0) begin
      in_empty = 1'b0;
      dividend = up_q[0][63:32];
      divisor  = up_q[0][31:0];
    end else begin
      in_empty = 1'b1;
      dividend = '0;
      divisor  = '0;
    end
    #1;
    pop_pending = in_rd_en;
    if (in_rd_en) chk("rd_only_idle", busy, 1'b0);
  end

  task automatic push_pair(input int a, input int b);
    up_q.push_back({a, b});
  endtask

  task automatic pop_out();
    out_rd_en = 1'b1;
    @(posedge clock);
    #1;
    out_rd_en = 1'b0;
    @(negedge clock);
    #2;
  endtask

  task automatic expect_one(input string tag, input logic [32:0] exp, input int lat);
    bit seen;
    int k;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      #2;
      if (in_rd_en) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_rd"}, seen, 1'b1);
    k = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      #2;
      k++;
      if (!out_empty) break;
    end
    chk({tag, "_lat"}, k, lat);
    chk({tag, "_q"}, {out_dz, out_dout}, exp);
    pop_out();
    chk({tag, "_drain"}, out_empty, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a, b, base;
    logic [32:0] tmp33;

    push_pair(3072, 2048);
    repeat (3) @(negedge clock);
    #2;
    chk("rst_in_rd_en", in_rd_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_empty", out_empty, 1'b1);
    chk("rst_out_dout", out_dout, 32'h0);
    chk("rst_out_dz", out_dz, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    expect_one("basic", {1'b0, 32'd1536}, LAT);

    push_pair(-7680, 2560);
    expect_one("signed", {1'b0, 32'hFFFF_F400}, LAT);
    push_pair(1024, 0);
    expect_one("dz_pos", {1'b1, 32'h7FFF_FFFF}, LAT_DZ);
    push_pair(-1024, 0);
    expect_one("dz_neg", {1'b1, 32'h8000_0000}, LAT_DZ);
    push_pair(32'h4000_0000, 1);
`ifdef DIVIDE_SAT_EN
    expect_one("ovf", {1'b0, 32'h7FFF_FFFF}, LAT);
`else
    expect_one("ovf", {1'b0, 32'h0000_0000}, LAT);
`endif

    // Reset around DIVIDE cycle 20 discards the operation.
    push_pair(3072, 2048);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      #2;
      if (in_rd_en) break;
    end
    repeat (20) @(negedge clock);
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    #2;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_empty", out_empty, 1'b1);
    repeat (60) @(negedge clock);
    #2;
    chk("midrst_no_write", out_empty, 1'b1);
    push_pair(-7680, 2560);
    expect_one("after_rst", {1'b0, 32'hFFFF_F400}, LAT);

    // Backpressure: 16 stored, 17th parked in WRITE, 18th must not be popped.
    base = rd_count;
    for (int i = 0; i < 18; i++) begin
      a = int'($urandom_range(0, 100000)) - 50000;
      b = int'($urandom_range(1, 5000));
      if ($urandom_range(0, 1) == 1) b = -b;
      push_pair(a, b);
      exp_q.push_back(model(a, b));
    end
    for (int i = 0; i < 2000 && (rd_count - base) < 17; i++) begin
      @(negedge clock);
      #2;
    end
    repeat (60) @(negedge clock);
    #2;
    chk("bp_rd_count", rd_count - base, 17);
    chk("bp_busy", busy, 1'b1);
    chk("bp_no_rd", in_rd_en, 1'b0);
    chk("bp_nonempty", out_empty, 1'b0);
    chk("bp_head", {out_dz, out_dout}, exp_q[0]);
    tmp33 = exp_q.pop_front();
    out_rd_en = 1'b1;
    @(posedge clock);
    #1;
    out_rd_en = 1'b0;
    @(negedge clock);
    #2;
    chk("bp_full_hold", busy, 1'b1);
    @(negedge clock);
    #2;
    chk("bp_17_written", busy, 1'b0);
    chk("bp_next_rd", in_rd_en, 1'b1);
    while (exp_q.size() > 0) begin
      for (int i = 0; i < 200 && out_empty; i++) begin
        @(negedge clock);
        #2;
      end
      chk("bp_avail", out_empty, 1'b0);
      chk("bp_order", {out_dz, out_dout}, exp_q[0]);
      tmp33 = exp_q.pop_front();
      pop_out();
    end
    chk("bp_total_rd", rd_count - base, 18);
    chk("bp_drained", out_empty, 1'b1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: begin a = int'($urandom); b = int'($urandom); end
        1: begin
          a = int'($urandom_range(0, 2000000)) - 1000000;
          b = int'($urandom_range(1, 200000)) - 100000;
        end
        2: begin a = int'($urandom); b = 0; end
        3: begin a = int'(32'h8000_0000); b = int'($urandom_range(0, 8)) - 4; end
        default: begin a = int'($urandom); b = int'($urandom_range(1, 4)); end
      endcase
      push_pair(a, b);
      expect_one("rnd", model(a, b), (b == 0) ? LAT_DZ : LAT);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
